// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable multi-channel 50%-duty clock divider with rising-edge ticks.
// Optional PHASE_SYNC_EN adds sync_pulse, which phase-aligns every channel in one cycle.
module clk_div_prog #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 49
) (
  input  logic              clk_100m,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr_en,
  input  logic [2:0]        div_wr_ch,
  input  logic [CNT_W-1:0]  div_wr_data,
`ifdef PHASE_SYNC_EN
  input  logic              sync_pulse,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_pend
);

  localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic sync_all;
`ifdef PHASE_SYNC_EN
  assign sync_all = sync_pulse;
`else
  assign sync_all = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      localparam logic [2:0] CH_IDX = 3'(gi);

      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] act_div_reg;
      logic [CNT_W-1:0] shadow_reg;
      logic             clk_out_reg;
      logic             tick_reg;
      logic             pend_reg;
      logic             running;
      logic             terminal;
      logic             wr_hit;
      logic             apply;

      // A high phase always runs to completion, so a channel stops only once clk_out is low.
      // A write landing in the apply cycle supersedes the older shadow and waits for the next boundary.
      always_comb begin
        running  = en[gi] | clk_out_reg;
        terminal = running & (cnt_reg == act_div_reg);
        wr_hit   = div_wr_en & (div_wr_ch == CH_IDX);
        apply    = pend_reg & ~wr_hit & (terminal | ~running | sync_all);
      end

      always_ff @(posedge clk_100m) begin
        if (rst) begin
          cnt_reg     <= '0;
          act_div_reg <= DEF_DIV_W;
          shadow_reg  <= DEF_DIV_W;
          clk_out_reg <= 1'b0;
          tick_reg    <= 1'b0;
          pend_reg    <= 1'b0;
        end else begin
          if (sync_all) begin
            cnt_reg     <= '0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
          end else begin
            tick_reg <= terminal & ~clk_out_reg;
            if (terminal) begin
              cnt_reg     <= '0;
              clk_out_reg <= ~clk_out_reg;
            end else if (running) begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end else begin
              cnt_reg <= '0;
            end
          end
          if (apply) begin
            act_div_reg <= shadow_reg;
            pend_reg    <= 1'b0;
          end
          if (wr_hit) begin
            shadow_reg <= div_wr_data;
            pend_reg   <= 1'b1;
          end
        end
      end

      assign clk_out[gi]  = clk_out_reg;
      assign tick[gi]     = tick_reg;
      assign div_pend[gi] = pend_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: timestamp-based channel model compared every cycle,
// directed scenarios with hand-computed cycle counts, then randomized traffic.
module tb_clk_div_prog;
  localparam int NUM_CH  = 2;
  localparam int CNT_W   = 16;
  localparam int DEF_DIV = 49;

  logic              clk_100m = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] en;
  logic              div_wr_en;
  logic [2:0]        div_wr_ch;
  logic [CNT_W-1:0]  div_wr_data;
  logic              sync_pulse;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_pend;

  int tests = 0;
  int fails = 0;

  always #5 clk_100m = ~clk_100m;

  clk_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
    .clk_100m   (clk_100m),
    .rst        (rst),
    .en         (en),
    .div_wr_en  (div_wr_en),
    .div_wr_ch  (div_wr_ch),
    .div_wr_data(div_wr_data),
`ifdef PHASE_SYNC_EN
    .sync_pulse (sync_pulse),
`endif
    .clk_out    (clk_out),
    .tick       (tick),
    .div_pend   (div_pend)
  );

  // Model: each half period is described by the edge number at which it began (t0);
  // it ends on the edge where (edge - t0) equals the active divisor.
  longint cyc = 0;
  longint t0 [NUM_CH];
  int     m_act [NUM_CH];
  int     m_sh [NUM_CH];
  bit     m_clk [NUM_CH];
  bit     m_tick [NUM_CH];
  bit     m_pend [NUM_CH];

  function automatic bit model_term(int ch);
    return (en[ch] || m_clk[ch]) && ((cyc - t0[ch]) == longint'(m_act[ch]));
  endfunction

  task automatic model_step();
    for (int ch = 0; ch < NUM_CH; ch++) begin
      bit run;
      bit term;
      bit hit;
      run  = en[ch] || m_clk[ch];
      term = model_term(ch);
      hit  = div_wr_en && (int'(div_wr_ch) == ch);
      if (rst) begin
        m_clk[ch]  = 1'b0;
        m_tick[ch] = 1'b0;
        m_pend[ch] = 1'b0;
        m_act[ch]  = DEF_DIV;
        m_sh[ch]   = DEF_DIV;
        t0[ch]     = cyc + 1;
      end else begin
        if (sync_pulse) begin
          m_clk[ch]  = 1'b0;
          m_tick[ch] = 1'b0;
          t0[ch]     = cyc + 1;
          if (m_pend[ch] && !hit) m_act[ch] = m_sh[ch];
          m_pend[ch] = 1'b0;
        end else begin
          m_tick[ch] = term && !m_clk[ch];
          if (term) m_clk[ch] = !m_clk[ch];
          if (term || !run) t0[ch] = cyc + 1;
          if (m_pend[ch] && !hit && (term || !run)) begin
            m_act[ch]  = m_sh[ch];
            m_pend[ch] = 1'b0;
          end
        end
        if (hit) begin
          m_sh[ch]   = int'(div_wr_data);
          m_pend[ch] = 1'b1;
        end
      end
    end
    cyc++;
  endtask

  task automatic check_outputs();
    logic [NUM_CH-1:0] ec, et, ep;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      ec[ch] = m_clk[ch];
      et[ch] = m_tick[ch];
      ep[ch] = m_pend[ch];
    end
    tests++;
    if (clk_out !== ec || tick !== et || div_pend !== ep) begin
      fails++;
      $display("FAIL cycle_cmp @%0d: clk_out=%b tick=%b div_pend=%b, expected %b %b %b",
               cyc, clk_out, tick, div_pend, ec, et, ep);
    end
  endtask

  task automatic cycle();
    @(posedge clk_100m);
    model_step();
    @(negedge clk_100m);
    check_outputs();
  endtask

  task automatic expect_eq(string name, int got, int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end else begin
      $display("[TB] %s: %0d as expected", name, got);
    end
  endtask

  task automatic do_write(int ch, int d);
    div_wr_en   = 1'b1;
    div_wr_ch   = 3'(ch);
    div_wr_data = CNT_W'(d);
    cycle();
    div_wr_en   = 1'b0;
    $display("[TB] write ch=%0d D=%0d @%0d", ch, d, cyc);
  endtask

  task automatic wait_level(int ch, logic lvl, int limit, output int n);
    n = 0;
    while (clk_out[ch] !== lvl && n < limit) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    int n, n1, n2, k, ticks;
    logic l1;
    rst         = 1'b1;
    en          = '1;
    div_wr_en   = 1'b0;
    div_wr_ch   = '0;
    div_wr_data = '0;
    sync_pulse  = 1'b0;

    // Reset and default 1 MHz operation
    cycle();
    cycle();
    expect_eq("reset_clk_out", int'(clk_out), 0);
    expect_eq("reset_tick", int'(tick), 0);
    expect_eq("reset_div_pend", int'(div_pend), 0);
    rst = 1'b0;
    wait_level(0, 1'b1, 200, n);
    expect_eq("first_rise_ch0", n, 50);
    expect_eq("tick_at_rise_ch0", int'(tick[0]), 1);
    expect_eq("div_pend_idle", int'(div_pend), 0);
    wait_level(0, 1'b0, 200, n1);
    wait_level(0, 1'b1, 200, n2);
    expect_eq("default_period_ch0", n1 + n2, 100);

    // Write during high phase: current half period completes unchanged
    repeat (10) cycle();
    do_write(0, 4);
    expect_eq("pend_after_write_ch0", int'(div_pend[0]), 1);
    wait_level(0, 1'b0, 200, n);
    expect_eq("rest_of_high_ch0", n, 39);
    expect_eq("pend_cleared_ch0", int'(div_pend[0]), 0);
    wait_level(0, 1'b1, 200, n);
    expect_eq("new_low_half_ch0", n, 5);
    wait_level(0, 1'b0, 200, n1);
    wait_level(0, 1'b1, 200, n2);
    expect_eq("new_period_ch0", n1 + n2, 10);

    // Write in the exact terminal cycle of ch1: applied one half period later
    k = 0;
    while (!model_term(1) && k < 300) begin
      cycle();
      k++;
    end
    do_write(1, 9);
    l1 = clk_out[1];
    expect_eq("pend_after_term_write_ch1", int'(div_pend[1]), 1);
    wait_level(1, ~l1, 200, n);
    expect_eq("old_half_ch1", n, 50);
    expect_eq("pend_cleared_ch1", int'(div_pend[1]), 0);
    wait_level(1, l1, 200, n);
    expect_eq("new_half_ch1", n, 10);

    // Disable mid high phase, then re-enable
    do_write(0, 49);
    k = 0;
    while (div_pend[0] !== 1'b0 && k < 200) begin
      cycle();
      k++;
    end
    wait_level(0, 1'b0, 200, n);
    wait_level(0, 1'b1, 200, n);
    repeat (10) cycle();
    en[0] = 1'b0;
    wait_level(0, 1'b0, 200, n);
    expect_eq("high_after_disable_ch0", n, 40);
    ticks = 0;
    repeat (120) begin
      cycle();
      if (tick[0] === 1'b1 || clk_out[0] !== 1'b0) ticks++;
    end
    expect_eq("idle_activity_ch0", ticks, 0);
    en[0] = 1'b1;
    wait_level(0, 1'b1, 200, n);
    expect_eq("reenable_rise_ch0", n, 50);

`ifdef PHASE_SYNC_EN
    // Phase alignment of related divisors
    do_write(0, 1);
    do_write(1, 3);
    k = 0;
    while (div_pend !== '0 && k < 200) begin
      cycle();
      k++;
    end
    repeat (7) cycle();
    sync_pulse = 1'b1;
    cycle();
    sync_pulse = 1'b0;
    expect_eq("sync_clk_out", int'(clk_out), 0);
    n1 = 0;
    n2 = 0;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      if (clk_out[0] === 1'b1 && n1 == 0) n1 = i;
      if (clk_out[1] === 1'b1 && n2 == 0) n2 = i;
    end
    expect_eq("sync_rise_ch0", n1, 2);
    expect_eq("sync_rise_ch1", n2, 4);
`endif

    // Out-of-range write is ignored; reset mid-period restores defaults
    repeat (60) cycle();
    expect_eq("pend_before_bad_write", int'(div_pend), 0);
    do_write(5, 3);
    expect_eq("pend_after_bad_write", int'(div_pend), 0);
    repeat (17) cycle();
    rst = 1'b1;
    cycle();
    expect_eq("midrst_clk_out", int'(clk_out), 0);
    expect_eq("midrst_tick", int'(tick), 0);
    expect_eq("midrst_div_pend", int'(div_pend), 0);
    rst = 1'b0;
    wait_level(1, 1'b1, 200, n);
    expect_eq("post_rst_rise_ch1", n, 50);

    // Randomized traffic checked every cycle against the model
    for (int i = 0; i < 4000; i++) begin
      for (int ch = 0; ch < NUM_CH; ch++)
        if ($urandom_range(0, 63) == 0) en[ch] = ~en[ch];
      div_wr_en   = ($urandom_range(0, 7) == 0);
      div_wr_ch   = 3'($urandom_range(0, 7));
      div_wr_data = CNT_W'($urandom_range(0, 6));
      rst         = ($urandom_range(0, 999) == 0);
`ifdef PHASE_SYNC_EN
      sync_pulse  = ($urandom_range(0, 299) == 0);
`endif
      cycle();
    end
    div_wr_en  = 1'b0;
    rst        = 1'b0;
    sync_pulse = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
